// File: rtl/pic_vec_if.sv
// pic_vec_if: bus and interrupt signals of the pic_vec interrupt controller.
//   din/address/w_en/r_en/dout : 8-bit peripheral programming bus
//   irq                        : peripheral requests, synchronous to clk
//   interrupt/intVect/intAck   : CPU request, handler address, acknowledge
// The slave modport is the controller side; the master modport is the
// CPU/bus side.
interface pic_vec_if #(
  parameter int NUM_IRQ = 8
) ();
  logic [7:0]         din;
  logic [7:0]         address;
  logic               w_en;
  logic               r_en;
  logic [7:0]         dout;
  logic [NUM_IRQ-1:0] irq;
  logic               interrupt;
  logic [15:0]        intVect;
  logic               intAck;

  modport slave (
    input  din, address, w_en, r_en, irq, intAck,
    output dout, interrupt, intVect
  );

  modport master (
    output din, address, w_en, r_en, irq, intAck,
    input  dout, interrupt, intVect
  );
endinterface

// File: rtl/pic_vec.sv
// pic_vec: parametrised programmable interrupt controller for up to 16
// channels. Each channel has a 16-bit handler vector, an enable bit, an
// edge/level trigger mode, and software-visible pending and in-service state.
// The lowest-numbered enabled pending channel is presented to the CPU.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : pic_vec_if.slave (programming bus, irq lines, CPU handshake)
// Register window (offsets from PIC_ADDRESS):
//   0..31 VECT lo/hi, 32/33 MASK, 34/35 PEND (W1C), 36/37 ISR,
//   38 STATUS {current, 2'b0, in_service, interrupt}, 39 EOI (write-only).
module pic_vec #(
  parameter logic [7:0]  PIC_ADDRESS = 8'h00,
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] EDGE_MASK   = 16'hFFFF,
  parameter bit          AUTO_EOI    = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  pic_vec_if.slave bus
);

  // Channels at or above NUM_IRQ are forced to zero in every register.
  localparam logic [15:0] VALID = 16'((32'd1 << NUM_IRQ) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_e;

  // Address decode; the 9-bit difference catches addresses below the base.
  logic [8:0]  diff;
  logic [7:0]  off;
  logic        in_win;
  logic        wr;

  assign diff   = {1'b0, bus.address} - {1'b0, PIC_ADDRESS};
  assign off    = diff[7:0];
  assign in_win = !diff[8] && (off < 8'd40);
  assign wr     = bus.w_en && in_win;

  state_e      state_q, state_d;
  logic [15:0] vect_q [16];
  logic [15:0] vect_d [16];
  logic [15:0] mask_q, mask_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] isr_q, isr_d;
  logic [15:0] irq_prev_q, irq_prev_d;
  logic [3:0]  current_q, current_d;
  logic [7:0]  dout_q, dout_d;
  logic        interrupt_q, interrupt_d;
  logic [15:0] int_vect_q, int_vect_d;

  logic [15:0] irq16;
  logic [15:0] set_v;
  logic [15:0] w1c;
  logic [15:0] ack_clr;
  logic [15:0] pend_keep;
  logic [15:0] req_v;
  logic [3:0]  low_idx;
  logic [7:0]  rdata;

  assign irq16 = 16'(bus.irq);

  // Programmable registers and pending-set sources.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    vect_d = vect_q;
    mask_d = mask_q;
    w1c    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (wr && off == 8'(2 * i))     vect_d[i][7:0]  = bus.din;
      if (wr && off == 8'(2 * i + 1)) vect_d[i][15:8] = bus.din;
    end
    if (wr && off == 8'd32) mask_d[7:0]  = bus.din;
    if (wr && off == 8'd33) mask_d[15:8] = bus.din;
    mask_d = mask_d & VALID;
    if (wr && off == 8'd34) w1c[7:0]  = bus.din;
    if (wr && off == 8'd35) w1c[15:8] = bus.din;
    set_v      = ((EDGE_MASK & irq16 & ~irq_prev_q) | (~EDGE_MASK & irq16)) & VALID;
    irq_prev_d = irq16;
  end

  // Lowest-numbered enabled pending channel wins.
  assign req_v = pend_q & mask_q;

  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (req_v[i]) low_idx = 4'(i);
    end
  end

  // Pending as it would be next cycle without an ack; used to notice that
  // the channel being requested was cleared or masked away by software.
  assign pend_keep = (pend_q & ~w1c) | set_v;

  // Request FSM.
  always_comb begin
    state_d     = state_q;
    current_d   = current_q;
    interrupt_d = interrupt_q;
    int_vect_d  = int_vect_q;
    isr_d       = isr_q;
    ack_clr     = '0;
    unique case (state_q)
      S_IDLE: begin
        interrupt_d = 1'b0;
        if (|req_v) begin
          current_d   = low_idx;
          int_vect_d  = vect_d[low_idx];
          interrupt_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        interrupt_d = 1'b1;
        // Tracking vect_d lets a vector rewrite show up on the next cycle.
        int_vect_d  = vect_d[current_q];
        if (bus.intAck) begin
          ack_clr     = 16'(1) << current_q;
          interrupt_d = 1'b0;
          if (AUTO_EOI) begin
            // Service ends at the ack itself, so ISR never holds a bit.
            state_d = S_IDLE;
          end else begin
            isr_d   = 16'(1) << current_q;
            state_d = S_SVC;
          end
        end else if (!(pend_keep[current_q] && mask_d[current_q])) begin
          interrupt_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_SVC: begin
        interrupt_d = 1'b0;
        if (wr && off == 8'd39) begin
          isr_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        interrupt_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    // A new set in the same cycle beats both W1C and the ack clear.
    pend_d = ((pend_q & ~(w1c | ack_clr)) | set_v) & VALID;
  end

  // Read mux; dout holds its value between reads.
  always_comb begin
    rdata = '0;
    if (in_win) begin
      if (off < 8'd32) begin
        rdata = off[0] ? vect_q[off[4:1]][15:8] : vect_q[off[4:1]][7:0];
      end else begin
        unique case (off)
          8'd32:   rdata = mask_q[7:0];
          8'd33:   rdata = mask_q[15:8];
          8'd34:   rdata = pend_q[7:0];
          8'd35:   rdata = pend_q[15:8];
          8'd36:   rdata = isr_q[7:0];
          8'd37:   rdata = isr_q[15:8];
          8'd38:   rdata = {current_q, 2'b00, state_q == S_SVC, interrupt_q};
          default: rdata = '0;
        endcase
      end
    end
    dout_d = bus.r_en ? rdata : dout_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before this edge, independent of statement order.
  // NOTE: the vector table is small and software-visible, so it is cleared
  // by reset like the other registers instead of being left as bare RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < 16; i++) vect_q[i] <= '0;
      mask_q      <= '0;
      pend_q      <= '0;
      isr_q       <= '0;
      irq_prev_q  <= '0;
      current_q   <= '0;
      dout_q      <= '0;
      interrupt_q <= 1'b0;
      int_vect_q  <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < 16; i++) vect_q[i] <= vect_d[i];
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      isr_q       <= isr_d;
      irq_prev_q  <= irq_prev_d;
      current_q   <= current_d;
      dout_q      <= dout_d;
      interrupt_q <= interrupt_d;
      int_vect_q  <= int_vect_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.interrupt = interrupt_q;
  assign bus.intVect   = int_vect_q;

endmodule

// File: tb/tb_pic_vec.sv
// tb_pic_vec: directed self-checking bench for pic_vec.
// dut_a: base 0x00, auto-EOI, channel 0 level-triggered, others edge.
// dut_b: base 0x40, explicit EOI, all channels edge-triggered.
module tb_pic_vec;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pic_vec_if #(.NUM_IRQ(8)) a_if ();
  pic_vec_if #(.NUM_IRQ(8)) b_if ();

  pic_vec #(
    .PIC_ADDRESS(8'h00),
    .NUM_IRQ    (8),
    .EDGE_MASK  (16'hFFFE),
    .AUTO_EOI   (1'b1)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (a_if)
  );

  pic_vec #(
    .PIC_ADDRESS(8'h40),
    .NUM_IRQ    (8),
    .EDGE_MASK  (16'hFFFF),
    .AUTO_EOI   (1'b0)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges; return just after the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [7:0] addr, input logic [7:0] data);
    a_if.address = addr;
    a_if.din     = data;
    a_if.w_en    = 1'b1;
    tick();
    a_if.w_en    = 1'b0;
  endtask

  task automatic rd_a(input logic [7:0] addr, output logic [7:0] data);
    a_if.address = addr;
    a_if.r_en    = 1'b1;
    tick();
    a_if.r_en    = 1'b0;
    data         = a_if.dout;
  endtask

  task automatic wr_b(input logic [7:0] addr, input logic [7:0] data);
    b_if.address = addr;
    b_if.din     = data;
    b_if.w_en    = 1'b1;
    tick();
    b_if.w_en    = 1'b0;
  endtask

  task automatic rd_b(input logic [7:0] addr, output logic [7:0] data);
    b_if.address = addr;
    b_if.r_en    = 1'b1;
    tick();
    b_if.r_en    = 1'b0;
    data         = b_if.dout;
  endtask

  initial begin
    logic [7:0] rd;
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    a_if.din = '0; a_if.address = '0; a_if.w_en = 1'b0; a_if.r_en = 1'b0;
    a_if.irq = '0; a_if.intAck = 1'b0;
    b_if.din = '0; b_if.address = '0; b_if.w_en = 1'b0; b_if.r_en = 1'b0;
    b_if.irq = '0; b_if.intAck = 1'b0;

    // Reset state
    tick(2);
    reset = 1'b1;
    check("rst_interrupt", 32'(a_if.interrupt), 32'd0);
    check("rst_intvect",   32'(a_if.intVect),   32'd0);
    check("rst_dout",      32'(a_if.dout),      32'd0);

    // Single edge request on channel 2
    wr_a(8'd4, 8'h34);
    wr_a(8'd5, 8'h12);
    wr_a(8'd32, 8'h04);
    a_if.irq = 8'h04;
    tick();
    a_if.irq = 8'h00;
    check("ch2_latency_n1", 32'(a_if.interrupt), 32'd0);
    tick();
    check("ch2_interrupt", 32'(a_if.interrupt), 32'd1);
    check("ch2_intvect",   32'(a_if.intVect),   32'h1234);
    a_if.intAck = 1'b1;
    tick();
    a_if.intAck = 1'b0;
    check("ch2_ack_drop", 32'(a_if.interrupt), 32'd0);
    rd_a(8'd34, rd);
    check("ch2_pend_clear", 32'(rd), 32'h00);

    // Register boundaries: unimplemented bits, unmapped/WO reads, dout hold
    wr_a(8'd32, 8'hFF);
    wr_a(8'd33, 8'hFF);
    rd_a(8'd32, rd);
    check("mask_lo_read", 32'(rd), 32'hFF);
    tick();
    check("dout_hold", 32'(a_if.dout), 32'hFF);
    rd_a(8'd33, rd);
    check("mask_hi_unimpl", 32'(rd), 32'h00);
    rd_a(8'd32, rd);
    rd_a(8'd40, rd);
    check("unmapped_read", 32'(rd), 32'h00);
    rd_a(8'd32, rd);
    rd_a(8'd39, rd);
    check("eoi_wo_read", 32'(rd), 32'h00);

    // Priority: channels 5 and 1 together, 1 is served first
    wr_a(8'd2, 8'hCD);
    wr_a(8'd3, 8'hAB);
    wr_a(8'd10, 8'h55);
    wr_a(8'd11, 8'h55);
    a_if.irq = 8'h22;
    tick();
    a_if.irq = 8'h00;
    tick();
    check("prio_interrupt", 32'(a_if.interrupt), 32'd1);
    check("prio_vect1",     32'(a_if.intVect),   32'hABCD);
    rd_a(8'd38, rd);
    check("prio_status", 32'(rd), 32'h11);
    a_if.intAck = 1'b1;
    tick();
    a_if.intAck = 1'b0;
    check("prio_ack_drop", 32'(a_if.interrupt), 32'd0);
    tick();
    check("prio_ch5_req",  32'(a_if.interrupt), 32'd1);
    check("prio_vect5",    32'(a_if.intVect),   32'h5555);
    a_if.intAck = 1'b1;
    tick();
    a_if.intAck = 1'b0;

    // Masked channel 4 stays pending, mask enable raises it, W1C withdraws it
    wr_a(8'd8, 8'h44);
    wr_a(8'd9, 8'h04);
    wr_a(8'd32, 8'h00);
    a_if.irq = 8'h10;
    tick();
    a_if.irq = 8'h00;
    tick();
    check("masked_no_int", 32'(a_if.interrupt), 32'd0);
    rd_a(8'd34, rd);
    check("masked_pend", 32'(rd), 32'h10);
    wr_a(8'd32, 8'h10);
    tick();
    check("unmask_int",  32'(a_if.interrupt), 32'd1);
    check("unmask_vect", 32'(a_if.intVect),   32'h0444);
    wr_a(8'd8, 8'h99);
    check("vect_update_in_req", 32'(a_if.intVect), 32'h0499);
    wr_a(8'd34, 8'h10);
    check("w1c_drop", 32'(a_if.interrupt), 32'd0);
    tick();
    check("w1c_stays_low", 32'(a_if.interrupt), 32'd0);
    rd_a(8'd34, rd);
    check("w1c_pend", 32'(rd), 32'h00);

    // Level channel 0 held through intAck repeats the request
    wr_a(8'd32, 8'h01);
    a_if.irq = 8'h01;
    tick(2);
    check("level_int", 32'(a_if.interrupt), 32'd1);
    a_if.intAck = 1'b1;
    tick();
    a_if.intAck = 1'b0;
    check("level_ack_drop", 32'(a_if.interrupt), 32'd0);
    tick();
    check("level_repeat", 32'(a_if.interrupt), 32'd1);
    a_if.irq    = 8'h00;
    a_if.intAck = 1'b1;
    tick();
    a_if.intAck = 1'b0;
    tick();
    check("level_released", 32'(a_if.interrupt), 32'd0);
    rd_a(8'd34, rd);
    check("level_pend_clear", 32'(rd), 32'h00);

    // Edge channel 6: a new edge in the intAck cycle keeps it pending
    wr_a(8'd32, 8'h40);
    a_if.irq = 8'h40;
    tick();
    a_if.irq = 8'h00;
    tick();
    check("edge6_int", 32'(a_if.interrupt), 32'd1);
    a_if.irq    = 8'h40;
    a_if.intAck = 1'b1;
    tick();
    a_if.irq    = 8'h00;
    a_if.intAck = 1'b0;
    check("edge6_ack_drop", 32'(a_if.interrupt), 32'd0);
    tick();
    check("edge6_repeat", 32'(a_if.interrupt), 32'd1);
    a_if.intAck = 1'b1;
    tick();
    a_if.intAck = 1'b0;
    tick();
    check("edge6_done", 32'(a_if.interrupt), 32'd0);
    rd_a(8'd34, rd);
    check("edge6_pend_clear", 32'(rd), 32'h00);

    // Explicit EOI on dut_b (base 0x40)
    wr_b(8'h60, 8'hFF);
    wr_b(8'h40, 8'h00);
    wr_b(8'h41, 8'h01);
    wr_b(8'h46, 8'h00);
    wr_b(8'h47, 8'h03);
    b_if.irq = 8'h01;
    tick();
    b_if.irq = 8'h00;
    tick();
    check("eoi_ch0_int",  32'(b_if.interrupt), 32'd1);
    check("eoi_ch0_vect", 32'(b_if.intVect),   32'h0100);
    b_if.intAck = 1'b1;
    b_if.irq    = 8'h08;
    tick();
    b_if.intAck = 1'b0;
    b_if.irq    = 8'h00;
    check("svc_no_int", 32'(b_if.interrupt), 32'd0);
    tick();
    check("svc_still_no_int", 32'(b_if.interrupt), 32'd0);
    rd_b(8'h64, rd);
    check("svc_isr", 32'(rd), 32'h01);
    rd_b(8'h66, rd);
    check("svc_status", 32'(rd), 32'h02);
    rd_b(8'h62, rd);
    check("svc_pend3", 32'(rd), 32'h08);
    wr_b(8'h67, 8'h00);
    check("eoi_idle_no_int", 32'(b_if.interrupt), 32'd0);
    tick();
    check("eoi_ch3_int",  32'(b_if.interrupt), 32'd1);
    check("eoi_ch3_vect", 32'(b_if.intVect),   32'h0300);
    rd_b(8'h64, rd);
    check("eoi_isr_clear", 32'(rd), 32'h00);

    // Asynchronous reset in the middle of a request
    wr_a(8'd32, 8'h04);
    a_if.irq = 8'h04;
    tick();
    a_if.irq = 8'h00;
    tick();
    check("prereset_int",  32'(a_if.interrupt), 32'd1);
    check("prereset_vect", 32'(a_if.intVect),   32'h1234);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_int_a",  32'(a_if.interrupt), 32'd0);
    check("async_rst_vect_a", 32'(a_if.intVect),   32'd0);
    check("async_rst_int_b",  32'(b_if.interrupt), 32'd0);
    tick();
    reset = 1'b1;
    rd_a(8'd32, rd);
    check("rst_mask", 32'(rd), 32'h00);
    rd_a(8'd34, rd);
    check("rst_pend", 32'(rd), 32'h00);
    rd_a(8'd4, rd);
    check("rst_vect2", 32'(rd), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
